// File: rtl/operand_select_stage.sv
// operand_select_stage: registered operand-select and immediate-extension stage.
// Picks source/destination register addresses from decoded fields, builds the
// ALU immediate and the sign-extended PC offset, and fuses a BL prefix/suffix
// pair (hi11/lo11) into one 22-bit offset.
//
// Handshake: a beat transfers on the input when in_valid && in_ready, and a
// result transfers on the output when out_valid && out_ready. Once out_valid
// is high, every output holds stable until out_ready is seen high at a rising
// edge. in_ready may depend on out_ready and flush, but never on in_valid.
module operand_select_stage #(
  parameter int AW       = 3,
  parameter int NSRC     = 4,
  parameter int DATA_W   = 32,
  parameter int PC_W     = 16,
  parameter int PC_SHIFT = 0,
  localparam int SW      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NSRC*AW-1:0]  rs_fields,
  input  logic [2*AW-1:0]     rd_fields,
  input  logic [SW-1:0]       rsrcA_sel,
  input  logic [SW-1:0]       rsrcB_sel,
  input  logic                rdest_sel,
  input  logic [4:0]          immed5,
  input  logic [7:0]          immed8,
  input  logic [10:0]         immed11,
  input  logic [1:0]          imm_mode,
  input  logic                pc_offset_sel,
  input  logic                bl_hi,
  input  logic                bl_lo,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [AW-1:0]       addr_srcA,
  output logic [AW-1:0]       addr_srcB,
  output logic [AW-1:0]       addr_dest,
  output logic [DATA_W-1:0]   alu_immed,
  output logic [PC_W-1:0]     pc_offset,
  output logic                out_bl,
  output logic                out_err,
  output logic                state_dbg
);

  typedef enum logic {IDLE = 1'b0, PREFIX = 1'b1} state_t;

  // Wide enough to sign-extend the 22-bit raw offset past PC_W and the shift.
  localparam int EXT_W = 22 + PC_W + PC_SHIFT;

  state_t              state_q, state_d;
  logic [10:0]         hi_q, hi_d;
  logic                accept;
  logic                produce;
  logic                fused;
  logic                err_d;
  logic                pc_sel_eff;
  logic [AW-1:0]       src_a, src_b, dest;
  logic [DATA_W-1:0]   imm_d;
  logic [21:0]         raw_off;
  logic [EXT_W-1:0]    ext_off;
  logic [EXT_W-1:0]    shl_off;
  logic [PC_W-1:0]     pc_d;

  assign in_ready  = !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign state_dbg = (state_q == PREFIX);

  // Source/destination field selection; out-of-range source index picks field 0.
  always_comb begin
    src_a = rs_fields[AW-1:0];
    src_b = rs_fields[AW-1:0];
    for (int i = 0; i < NSRC; i++) begin
      if (rsrcA_sel == SW'(i)) src_a = rs_fields[i*AW +: AW];
      if (rsrcB_sel == SW'(i)) src_b = rs_fields[i*AW +: AW];
    end
    dest = rdest_sel ? rd_fields[2*AW-1:AW] : rd_fields[AW-1:0];
  end

  // Zero-extended ALU immediate by mode.
  always_comb begin
    imm_d = '0;
    case (imm_mode)
      2'b00:   imm_d = DATA_W'(immed8);
      2'b01:   imm_d = DATA_W'({immed5, 2'b00});
      2'b10:   imm_d = DATA_W'({immed5, 1'b0});
      default: imm_d = DATA_W'(immed5);
    endcase
  end

  // BL pairing FSM: next state, prefix capture and result classification.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    produce    = 1'b0;
    fused      = 1'b0;
    err_d      = 1'b0;
    pc_sel_eff = pc_offset_sel;
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (bl_hi) begin
            hi_d    = immed11;
            state_d = PREFIX;
          end else if (bl_lo) begin
            // Orphan suffix: still carries an 11-bit offset.
            produce    = 1'b1;
            err_d      = 1'b1;
            pc_sel_eff = 1'b1;
          end else begin
            produce = 1'b1;
          end
        end
        PREFIX: begin
          if (bl_lo) begin
            produce = 1'b1;
            fused   = 1'b1;
            state_d = IDLE;
          end else if (bl_hi) begin
            hi_d = immed11;
          end else begin
            produce = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // PC offset: pick 22-bit signed raw value, sign-extend, shift, truncate.
  always_comb begin
    if (fused)           raw_off = {hi_q, immed11};
    else if (pc_sel_eff) raw_off = {{11{immed11[10]}}, immed11};
    else                 raw_off = {{14{immed8[7]}}, immed8};
    ext_off = {{(EXT_W-22){raw_off[21]}}, raw_off};
    shl_off = ext_off << PC_SHIFT;
    pc_d    = shl_off[PC_W-1:0];
  end

  // FSM state and BL prefix register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
    end
  end

  // Output pipeline register: flush drops, a result loads, a take drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      addr_srcA <= '0;
      addr_srcB <= '0;
      addr_dest <= '0;
      alu_immed <= '0;
      pc_offset <= '0;
      out_bl    <= 1'b0;
      out_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (produce) begin
      out_valid <= 1'b1;
      addr_srcA <= src_a;
      addr_srcB <= src_b;
      addr_dest <= dest;
      alu_immed <= imm_d;
      pc_offset <= pc_d;
      out_bl    <= fused;
      out_err   <= err_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_select_stage.sv
// Directed bench for operand_select_stage. Three instances share all inputs:
// u32 (PC_W=32) is the main checked instance, u16 (default PC_W=16) and
// ush (PC_W=16, PC_SHIFT=1) check the narrow and shifted PC offsets.
module tb_operand_select_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [11:0] rs_fields;
  logic [5:0]  rd_fields;
  logic [1:0]  rsrcA_sel, rsrcB_sel;
  logic        rdest_sel;
  logic [4:0]  immed5;
  logic [7:0]  immed8;
  logic [10:0] immed11;
  logic [1:0]  imm_mode;
  logic        pc_offset_sel;
  logic        bl_hi, bl_lo;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_bl, a_err, a_st;
  logic [2:0]  a_sa, a_sb, a_d;
  logic [31:0] a_imm, a_pc;

  logic        b_in_ready, b_out_valid, b_bl, b_err, b_st;
  logic [2:0]  b_sa, b_sb, b_d;
  logic [31:0] b_imm;
  logic [15:0] b_pc;

  logic        c_in_ready, c_out_valid, c_bl, c_err, c_st;
  logic [2:0]  c_sa, c_sb, c_d;
  logic [31:0] c_imm;
  logic [15:0] c_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  operand_select_stage #(.PC_W(32)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .rs_fields(rs_fields), .rd_fields(rd_fields), .rsrcA_sel(rsrcA_sel), .rsrcB_sel(rsrcB_sel),
    .rdest_sel(rdest_sel), .immed5(immed5), .immed8(immed8), .immed11(immed11),
    .imm_mode(imm_mode), .pc_offset_sel(pc_offset_sel), .bl_hi(bl_hi), .bl_lo(bl_lo),
    .out_valid(a_out_valid), .out_ready(out_ready), .addr_srcA(a_sa), .addr_srcB(a_sb),
    .addr_dest(a_d), .alu_immed(a_imm), .pc_offset(a_pc), .out_bl(a_bl), .out_err(a_err),
    .state_dbg(a_st));

  operand_select_stage u16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .rs_fields(rs_fields), .rd_fields(rd_fields), .rsrcA_sel(rsrcA_sel), .rsrcB_sel(rsrcB_sel),
    .rdest_sel(rdest_sel), .immed5(immed5), .immed8(immed8), .immed11(immed11),
    .imm_mode(imm_mode), .pc_offset_sel(pc_offset_sel), .bl_hi(bl_hi), .bl_lo(bl_lo),
    .out_valid(b_out_valid), .out_ready(out_ready), .addr_srcA(b_sa), .addr_srcB(b_sb),
    .addr_dest(b_d), .alu_immed(b_imm), .pc_offset(b_pc), .out_bl(b_bl), .out_err(b_err),
    .state_dbg(b_st));

  operand_select_stage #(.PC_SHIFT(1)) ush (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .rs_fields(rs_fields), .rd_fields(rd_fields), .rsrcA_sel(rsrcA_sel), .rsrcB_sel(rsrcB_sel),
    .rdest_sel(rdest_sel), .immed5(immed5), .immed8(immed8), .immed11(immed11),
    .imm_mode(imm_mode), .pc_offset_sel(pc_offset_sel), .bl_hi(bl_hi), .bl_lo(bl_lo),
    .out_valid(c_out_valid), .out_ready(out_ready), .addr_srcA(c_sa), .addr_srcB(c_sb),
    .addr_dest(c_d), .alu_immed(c_imm), .pc_offset(c_pc), .out_bl(c_bl), .out_err(c_err),
    .state_dbg(c_st));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic hi, input logic lo, input logic sel,
                      input logic [7:0] i8, input logic [10:0] i11);
    in_valid      = 1'b1;
    bl_hi         = hi;
    bl_lo         = lo;
    pc_offset_sel = sel;
    immed8        = i8;
    immed11       = i11;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    bl_hi    = 1'b0;
    bl_lo    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rs_fields = {3'd7, 3'd5, 3'd2, 3'd1};
    rd_fields = {3'd6, 3'd4};
    rsrcA_sel = 2'd2; rsrcB_sel = 2'd3; rdest_sel = 1'b1;
    immed5 = 5'h1F; immed8 = 8'h00; immed11 = 11'h000; imm_mode = 2'b01;
    pc_offset_sel = 1'b0; bl_hi = 1'b0; bl_lo = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_alu_immed", a_imm, 32'd0);
    chk("rst_pc_offset", a_pc, 32'd0);
    chk("rst_state", {31'd0, a_st}, 32'd0);
    rst = 1'b0;

    // Selects and imm mode 01, immed8 sign extension
    beat(1'b0, 1'b0, 1'b0, 8'h80, 11'h000);
    imm_mode = 2'b01;
    #1 chk("in_ready_idle", {31'd0, a_in_ready}, 32'd1);
    tick();
    chk("m01_valid", {31'd0, a_out_valid}, 32'd1);
    chk("srcA", {29'd0, a_sa}, 32'd5);
    chk("srcB", {29'd0, a_sb}, 32'd7);
    chk("dest", {29'd0, a_d}, 32'd6);
    chk("m01_immed", a_imm, 32'h7C);
    chk("pc8_w16", {16'd0, b_pc}, 32'hFF80);
    chk("pc8_w32", a_pc, 32'hFFFFFF80);
    chk("pc8_sh1", {16'd0, c_pc}, 32'hFF00);

    // Mode 10, immed11 positive
    imm_mode = 2'b10;
    beat(1'b0, 1'b0, 1'b1, 8'h80, 11'h3FF);
    tick();
    chk("m10_immed", a_imm, 32'h3E);
    chk("pc11_w16", {16'd0, b_pc}, 32'h03FF);

    // Mode 11, immed11 negative with shift
    imm_mode = 2'b11;
    beat(1'b0, 1'b0, 1'b1, 8'h80, 11'h400);
    tick();
    chk("m11_immed", a_imm, 32'h1F);
    chk("pc11_sh1", {16'd0, c_pc}, 32'hF800);
    chk("pc11n_w16", {16'd0, b_pc}, 32'hFC00);

    // Mode 00, then drain with no new beat
    imm_mode = 2'b00;
    beat(1'b0, 1'b0, 1'b0, 8'hA5, 11'h000);
    tick();
    chk("m00_immed", a_imm, 32'hA5);
    idle();
    tick();
    chk("drain_valid", {31'd0, a_out_valid}, 32'd0);
    chk("drain_hold", a_imm, 32'hA5);

    // BL fusion 0x7FF / 0x001
    beat(1'b1, 1'b0, 1'b0, 8'h00, 11'h7FF);
    tick();
    chk("pre_no_valid", {31'd0, a_out_valid}, 32'd0);
    chk("pre_state", {31'd0, a_st}, 32'd1);
    beat(1'b0, 1'b1, 1'b0, 8'h00, 11'h001);
    tick();
    chk("fuse_valid", {31'd0, a_out_valid}, 32'd1);
    chk("fuse_pc", a_pc, 32'hFFFFF801);
    chk("fuse_bl", {31'd0, a_bl}, 32'd1);
    chk("fuse_err", {31'd0, a_err}, 32'd0);
    chk("fuse_state", {31'd0, a_st}, 32'd0);
    idle();
    tick();

    // bl_lo in IDLE: error, offset taken from immed11
    beat(1'b0, 1'b1, 1'b0, 8'h7F, 11'h001);
    tick();
    chk("orph_err", {31'd0, a_err}, 32'd1);
    chk("orph_bl", {31'd0, a_bl}, 32'd0);
    chk("orph_pc", a_pc, 32'h1);

    // bl_hi then a normal beat
    beat(1'b1, 1'b0, 1'b0, 8'h00, 11'h7FF);
    tick();
    beat(1'b0, 1'b0, 1'b0, 8'h05, 11'h000);
    tick();
    chk("brk_err", {31'd0, a_err}, 32'd1);
    chk("brk_bl", {31'd0, a_bl}, 32'd0);
    chk("brk_pc", a_pc, 32'h5);
    chk("brk_state", {31'd0, a_st}, 32'd0);

    // bl_hi, bl_hi(0x001), bl_lo(0x000)
    beat(1'b1, 1'b0, 1'b0, 8'h00, 11'h7FF);
    tick();
    beat(1'b1, 1'b0, 1'b0, 8'h00, 11'h001);
    tick();
    chk("rehi_state", {31'd0, a_st}, 32'd1);
    beat(1'b0, 1'b1, 1'b0, 8'h00, 11'h000);
    tick();
    chk("rehi_pc", a_pc, 32'h800);
    chk("rehi_bl", {31'd0, a_bl}, 32'd1);

    // Backpressure then back-to-back release
    beat(1'b0, 1'b0, 1'b0, 8'h11, 11'h000);
    tick();
    chk("bp_first", a_imm, 32'h11);
    out_ready = 1'b0;
    immed8 = 8'h22;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
      tick();
      chk("bp_valid", {31'd0, a_out_valid}, 32'd1);
      chk("bp_hold", a_imm, 32'h11);
    end
    out_ready = 1'b1;
    #1 chk("rel_in_ready", {31'd0, a_in_ready}, 32'd1);
    tick();
    chk("b2b_1_valid", {31'd0, a_out_valid}, 32'd1);
    chk("b2b_1", a_imm, 32'h22);
    immed8 = 8'h33;
    tick();
    chk("b2b_2_valid", {31'd0, a_out_valid}, 32'd1);
    chk("b2b_2", a_imm, 32'h33);

    // Flush while a result is held
    out_ready = 1'b0;
    immed8 = 8'h44;
    flush = 1'b1;
    #1 chk("fl_in_ready", {31'd0, a_in_ready}, 32'd0);
    tick();
    chk("fl_valid", {31'd0, a_out_valid}, 32'd0);
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    tick();
    chk("fl_no_accept", {31'd0, a_out_valid}, 32'd0);

    // Flush in PREFIX, beat in flush cycle dropped, then orphan bl_lo
    beat(1'b1, 1'b0, 1'b0, 8'h00, 11'h123);
    tick();
    chk("fl_pre_state", {31'd0, a_st}, 32'd1);
    beat(1'b0, 1'b1, 1'b0, 8'h00, 11'h004);
    flush = 1'b1;
    tick();
    chk("flp_valid", {31'd0, a_out_valid}, 32'd0);
    chk("flp_state", {31'd0, a_st}, 32'd0);
    flush = 1'b0;
    tick();
    chk("flp_err", {31'd0, a_err}, 32'd1);
    chk("flp_bl", {31'd0, a_bl}, 32'd0);
    chk("flp_pc", a_pc, 32'h4);

    // Async reset mid-BL pair
    beat(1'b0, 1'b0, 1'b0, 8'h66, 11'h000);
    tick();
    beat(1'b1, 1'b0, 1'b0, 8'h00, 11'h7FF);
    tick();
    chk("mid_state", {31'd0, a_st}, 32'd1);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, a_out_valid}, 32'd0);
    chk("arst_immed", a_imm, 32'd0);
    chk("arst_pc", a_pc, 32'd0);
    chk("arst_srcA", {29'd0, a_sa}, 32'd0);
    chk("arst_state", {31'd0, a_st}, 32'd0);
    tick();
    rst = 1'b0;
    beat(1'b0, 1'b1, 1'b0, 8'h00, 11'h001);
    tick();
    chk("post_rst_err", {31'd0, a_err}, 32'd1);
    chk("post_rst_bl", {31'd0, a_bl}, 32'd0);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_select_stage.md
# operand_select_stage

Registered, parametrised operand-select and immediate-extension stage that sits between the instruction decoder and the register file / ALU / branch unit. It selects source and destination register addresses from the decoded fields and produces zero-extended ALU immediates and sign-extended PC offsets. It adds a valid/ready pipeline register, a flush input and four immediate modes. It also includes a two-beat state machine that fuses a branch-with-link prefix/suffix pair (hi11/lo11) into one 22-bit PC offset.

## Interface
- AW, 3: register address width
- NSRC, 4: number of candidate source-register fields; SW = $clog2(NSRC)
- DATA_W, 32: ALU immediate width (≥ 8)
- PC_W, 16: PC offset width (≥ 11)
- PC_SHIFT, 0: left shift applied to every PC offset before output

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  drop held output and pending BL prefix
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept this cycle
- rs_fields  in  NSRC*AW  candidate sources; field i = bits [i*AW +: AW]
- rd_fields  in  2*AW  candidate destinations Rd0 (low), Rd1 (high)
- rsrcA_sel, rsrcB_sel  in  SW  source field index; index ≥ NSRC selects field 0
- rdest_sel  in  1  destination field index
- immed5 / immed8 / immed11  in  5 / 8 / 11  raw immediates
- imm_mode  in  2  ALU immediate mode
- pc_offset_sel  in  1  0: immed8 offset, 1: immed11 offset
- bl_hi, bl_lo  in  1  beat is BL prefix / BL suffix (never both)
- out_valid  out  1  output registers hold a result
- out_ready  in  1  consumer takes the result
- addr_srcA, addr_srcB, addr_dest  out  AW  selected addresses
- alu_immed  out  DATA_W  extended ALU immediate
- pc_offset  out  PC_W  extended, shifted PC offset
- out_bl  out  1  pc_offset is a fused 22-bit BL offset
- out_err  out  1  BL sequencing error on this result

## Operation
- Accept = in_valid && in_ready.
- in_ready = !flush && (!out_valid || out_ready).
- ALU immediate, zero-extended to DATA_W:
  - imm_mode 00: immed8
  - 01: immed5<<2 (word)
  - 10: immed5<<1 (half)
  - 11: immed5 (byte)
- PC offset raw value:
  - sign-extended immed8 (pc_offset_sel=0) or immed11 (pc_offset_sel=1)
  - BL fused: sign-extended {hi11, lo11} (22 bits)
  - Then shifted left by PC_SHIFT and truncated to the PC_W LSBs.
- State machine, states IDLE and PREFIX, with 11-bit hi_reg:
  - IDLE, accept bl_hi: hi_reg ← immed11, go to PREFIX; no result produced.
  - IDLE, accept bl_lo: normal result with pc_offset_sel treated as 1, out_bl=0, out_err=1.
  - IDLE, other accept: normal result, out_bl=0, out_err=0.
  - PREFIX, accept bl_lo: fused result, out_bl=1, out_err=0, go to IDLE.
  - PREFIX, accept bl_hi: hi_reg replaced, stay in PREFIX, no result.
  - PREFIX, other accept: prefix discarded, normal result with out_err=1, go to IDLE.
- Register addresses and alu_immed are captured on every result-producing accept, including the BL suffix.

## Timing
- Reset (async): out_valid=0; all data outputs, out_bl, out_err and hi_reg = 0; state IDLE.
- Latency: 1 cycle from a result-producing accept to out_valid=1 with data.
- Stall: while out_valid && !out_ready, all outputs hold stable and in_ready=0.
- Full throughput: accept and out_ready in the same cycle lets a new result replace the old one at the next edge with no bubble.
- Result consumed with no new result: out_valid clears at the next edge; data outputs keep their last values.
- A prefix-only accept does not set out_valid, but the current output may still drain.
- flush (synchronous, highest priority):
  - next edge: out_valid=0, state IDLE
  - the input beat in the flush cycle is not accepted (in_ready=0)
- Reset mid-BL pair: the prefix is lost; a following bl_lo is treated as an IDLE bl_lo (out_err=1).

## Test plan
- Selects and imm modes: rs_fields={3'd7,3'd5,3'd2,3'd1}, rsrcA_sel=2, rsrcB_sel=3, rd_fields={3'd6,3'd4}, rdest_sel=1, immed5=5'h1F; imm_mode 01/10/11 → addr_srcA=5, addr_srcB=7, addr_dest=6, alu_immed=0x7C / 0x3E / 0x1F, one cycle after each accept.
- Sign extension: immed8=0x80, pc_offset_sel=0 → pc_offset=0xFF80; immed11=0x3FF, pc_offset_sel=1 → 0x03FF; with PC_SHIFT=1, immed11=0x400 → 0xF800.
- BL fusion, PC_W=32: bl_hi immed11=0x7FF, then bl_lo immed11=0x001:
  - after the prefix: no out_valid
  - then a single result: pc_offset=0xFFFFF801, out_bl=1, out_err=0
- BL errors:
  - bl_lo in IDLE → out_err=1, out_bl=0
  - bl_hi followed by a normal beat → out_err=1, state IDLE
  - bl_hi, bl_hi(0x001), bl_lo(0x000) → fused offset 0x00000800
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable; release → back-to-back results with no bubble.
- Flush and reset:
  - flush while out_valid=1 and in PREFIX → out_valid=0 at the next edge, beat in the flush cycle not accepted, then bl_lo gives out_err=1
  - assert rst mid-stream → all outputs 0 immediately (asynchronous)
